shift_reg_tx_4b: RTL and testbench

SHIFT_REG_TX_4B -- requirements
Module: shift_reg_tx_4b

---
 rtl/shift_reg_tx_4b_pkg.sv | 16 +
 rtl/shift_reg_tx_4b_tx_bit_counter.sv | 40 ++++
 rtl/shift_reg_tx_4b.sv | 117 +++++++++++
 tb/tb_shift_reg_tx_4b.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_tx_4b_pkg.sv
// Shared types and constants for the 4-bit serial transmitter/receiver pair.
package shift_reg_tx_4b_pkg;

  // Transmitter control states.
  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } tx_state_e;

  // Frame order, named after the receiver's shift direction.
  // DIR_RIGHT: receiver shifts Q0->Q3, so the MSB goes out first.
  // DIR_LEFT:  receiver shifts Q3->Q0, so the LSB goes out first.
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;

endpackage

// File: rtl/shift_reg_tx_4b_tx_bit_counter.sv
// Bit counter for one serialized frame: sync clear, enable, flag on the last bit.
module shift_reg_tx_4b_tx_bit_counter #(
  parameter int unsigned Width = 4,
  parameter int unsigned CntW  = $clog2(Width)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  output logic [CntW-1:0] cnt,
  output logic            last
);

  localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  // Next count: clear wins, wrap to 0 after the last bit so cnt never exceeds Width-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == LastCnt);

endmodule

// File: rtl/shift_reg_tx_4b.sv
// Parallel-to-serial transmitter: loads a WIDTH-bit word on a valid/ready handshake
// and emits it one bit per clock, MSB or LSB first, with back-to-back frame support.
module shift_reg_tx_4b
  import shift_reg_tx_4b_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             direccion,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             d,
  output logic             d_valid,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH);

  tx_state_e        state_d, state_q;
  logic [WIDTH-1:0] sr_d, sr_q;
  logic             dir_d, dir_q;
  logic [CntW-1:0]  cnt;
  logic             cnt_last;
  logic             last_bit;
  logic             load;
  logic             shifting;

  assign shifting = (state_q == StShift);
  assign last_bit = shifting && cnt_last;
  assign load     = load_valid && load_ready;

  // Counter restarts on every load; otherwise advances once per emitted bit.
  shift_reg_tx_4b_tx_bit_counter #(
    .Width (WIDTH),
    .CntW  (CntW)
  ) u_tx_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (load),
    .en   (shifting),
    .cnt  (cnt),
    .last (cnt_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a load always (re)enters StShift; the last bit returns to idle otherwise.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (load) state_d = StShift;
      end
      StShift: begin
        if (last_bit && !load) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: d is taken straight from the register end selected by the latched direction.
  always_comb begin
    load_ready = 1'b0;
    d_valid    = 1'b0;
    d          = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        load_ready = 1'b1;
      end
      StShift: begin
        d_valid    = 1'b1;
        d          = (dir_q == DIR_RIGHT) ? sr_q[WIDTH-1] : sr_q[0];
        done       = cnt_last;
        load_ready = cnt_last;
      end
      default: ;
    endcase
  end

  // Datapath next state: capture on load, otherwise shift toward the output end, zero fill.
  always_comb begin
    sr_d  = sr_q;
    dir_d = dir_q;
    if (load) begin
      sr_d  = din;
      dir_d = direccion;
    end else if (shifting) begin
      if (dir_q == DIR_RIGHT) begin
        sr_d = {sr_q[WIDTH-2:0], 1'b0};
      end else begin
        sr_d = {1'b0, sr_q[WIDTH-1:1]};
      end
    end
  end

  // Shift register and latched direction, both cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      dir_q <= DIR_LEFT;
    end else begin
      sr_q  <= sr_d;
      dir_q <= dir_d;
    end
  end

endmodule

// File: tb/tb_shift_reg_tx_4b.sv
// Scoreboard bench for shift_reg_tx_4b: expected serial bits are queued when a load
// is accepted and compared each cycle; a behavioural receiver checks the loopback word.
module tb_shift_reg_tx_4b;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic b;
    logic last;
  } bit_exp_t;

  typedef struct packed {
    logic [W-1:0] w;
    logic         dir;
  } word_exp_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic         direccion;
  logic         load_valid;
  logic         load_ready;
  logic         d;
  logic         d_valid;
  logic         done;

  bit_exp_t     bq[$];
  word_exp_t    wq[$];
  logic [W-1:0] rx;
  bit           chk_en;
  int           errors;
  int           checks;

  shift_reg_tx_4b #(
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .direccion  (direccion),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .d          (d),
    .d_valid    (d_valid),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: advance at each rising edge using pre-edge input values.
  always @(posedge clk) begin
    bit rdy;
    rdy = (bq.size() <= 1);
    if (rst) begin
      bq.delete();
      wq.delete();
      rx     = '0;
      chk_en = 1'b1;
    end else if (chk_en) begin
      // Receiver shifts the observed serial stream in the matching direction.
      if (d_valid === 1'b1 && wq.size() > 0) begin
        rx = wq[0].dir ? {rx[W-2:0], d} : {d, rx[W-1:1]};
        if (done === 1'b1) begin
          check("loopback", 32'(rx), 32'(wq[0].w));
          void'(wq.pop_front());
        end
      end
      if (bq.size() > 0) void'(bq.pop_front());
      if (load_valid && rdy) begin
        for (int i = 0; i < W; i++) begin
          bit_exp_t e;
          e.b    = direccion ? din[W-1-i] : din[i];
          e.last = (i == W - 1);
          bq.push_back(e);
        end
        wq.push_back('{w: din, dir: direccion});
      end
    end
  end

  // Compare DUT outputs mid-cycle against the head of the scoreboard.
  always @(negedge clk) begin
    if (chk_en) begin
      if (bq.size() > 0) begin
        check("d_valid", 32'(d_valid), 32'd1);
        check("d", 32'(d), 32'(bq[0].b));
        check("done", 32'(done), 32'(bq[0].last));
        check("load_ready_shift", 32'(load_ready), 32'(bq.size() == 1));
      end else begin
        check("idle_d_valid", 32'(d_valid), 32'd0);
        check("idle_d", 32'(d), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_load_ready", 32'(load_ready), 32'd1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer a word and wait (bounded) for the handshake edge.
  task automatic send(input logic [W-1:0] w, input logic dir, input bit keep);
    int n;
    din        = w;
    direccion  = dir;
    load_valid = 1'b1;
    n = 0;
    while (load_ready !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    if (n >= 50) check("send_timeout", 32'd0, 32'd1);
    tick(1);
    if (!keep) load_valid = 1'b0;
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    chk_en     = 1'b0;
    rst        = 1'b1;
    din        = '0;
    direccion  = 1'b0;
    load_valid = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);

    // MSB-first and LSB-first single frames.
    send(4'b1011, 1'b1, 1'b0);
    tick(6);
    send(4'b1011, 1'b0, 1'b0);
    tick(6);

    // Held load_valid: two back-to-back frames.
    send(4'hA, 1'b1, 1'b1);
    send(4'h5, 1'b1, 1'b0);
    tick(6);

    // Inputs change mid-frame, including an ignored load_valid.
    send(4'b0110, 1'b1, 1'b0);
    din        = 4'b1001;
    direccion  = 1'b0;
    load_valid = 1'b1;
    tick(1);
    load_valid = 1'b0;
    tick(6);

    // Reset mid-frame, with a simultaneous load request that must lose.
    send(4'b1111, 1'b1, 1'b0);
    tick(1);
    rst        = 1'b1;
    load_valid = 1'b1;
    din        = 4'b0101;
    tick(1);
    rst        = 1'b0;
    load_valid = 1'b0;
    tick(4);

    // Loopback over every value and both directions, back to back.
    for (int dir = 0; dir < 2; dir++) begin
      for (int v = 0; v < (1 << W); v++) begin
        send(W'(v), dir[0], 1'b1);
      end
    end
    load_valid = 1'b0;
    tick(8);

    check("drain_bits", 32'(bq.size()), 32'd0);
    check("drain_words", 32'(wq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
